// File: rtl/wb_regfile_if.sv
// Bus between the ID/WB pipeline stages and wb_regfile: writeback commit,
// two operand reads, destination issue, and the hazard/error returns.
interface wb_regfile_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 3
);
  logic              WRegEn_WB;
  logic [ADDR_W-1:0] WReg1_WB;
  logic [DATA_W-1:0] Dout_WB;
  logic [ADDR_W-1:0] RReg1_ID;
  logic [ADDR_W-1:0] RReg2_ID;
  logic              REn1_ID;
  logic              REn2_ID;
  logic [DATA_W-1:0] Rdata1_ID;
  logic [DATA_W-1:0] Rdata2_ID;
  logic              IssueEn_ID;
  logic [ADDR_W-1:0] IssueReg_ID;
  logic              Stall_ID;
  logic              SbErr;

  modport master (
    output WRegEn_WB, WReg1_WB, Dout_WB,
    output RReg1_ID, RReg2_ID, REn1_ID, REn2_ID,
    output IssueEn_ID, IssueReg_ID,
    input  Rdata1_ID, Rdata2_ID, Stall_ID, SbErr
  );

  modport slave (
    input  WRegEn_WB, WReg1_WB, Dout_WB,
    input  RReg1_ID, RReg2_ID, REn1_ID, REn2_ID,
    input  IssueEn_ID, IssueReg_ID,
    output Rdata1_ID, Rdata2_ID, Stall_ID, SbErr
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback register file with per-register pending-write scoreboard.
// Define WB_BYPASS_EN for same-cycle WB-to-ID forwarding and hazard relief.
module wb_regfile #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  wb_regfile_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic [DEPTH-1:0][1:0]      cnt_q;
  logic [DEPTH-1:0][1:0]      cnt_d;
  logic [DEPTH-1:0]           err_vec;
  logic                       sberr_q;
  logic                       sberr_d;
  logic                       iss;
  logic                       haz_a;
  logic                       haz_b;
  logic [DATA_W-1:0]          rdata1;
  logic [DATA_W-1:0]          rdata2;

  // Only the count that existed before this edge matters, so a source equal
  // to the issuing destination never hazards against itself.
  always_comb begin
    haz_a  = bus.REn1_ID && (cnt_q[bus.RReg1_ID] != 2'd0);
    haz_b  = bus.REn2_ID && (cnt_q[bus.RReg2_ID] != 2'd0);
    rdata1 = mem_q[bus.RReg1_ID];
    rdata2 = mem_q[bus.RReg2_ID];
`ifdef WB_BYPASS_EN
    if (bus.WRegEn_WB && (bus.WReg1_WB == bus.RReg1_ID)) begin
      rdata1 = bus.Dout_WB;
      if (cnt_q[bus.RReg1_ID] == 2'd1) haz_a = 1'b0;
    end
    if (bus.WRegEn_WB && (bus.WReg1_WB == bus.RReg2_ID)) begin
      rdata2 = bus.Dout_WB;
      if (cnt_q[bus.RReg2_ID] == 2'd1) haz_b = 1'b0;
    end
`else
`endif
  end

  assign iss = bus.IssueEn_ID && !(haz_a || haz_b);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb
      logic inc;
      logic dec;
      assign inc = iss && (bus.IssueReg_ID == ADDR_W'(gi));
      assign dec = bus.WRegEn_WB && (bus.WReg1_WB == ADDR_W'(gi));
      // Saturate at both ends; the error flag records the lost event.
      assign cnt_d[gi] = (inc && !dec && cnt_q[gi] != 2'd3) ? cnt_q[gi] + 2'd1 :
                         (dec && !inc && cnt_q[gi] != 2'd0) ? cnt_q[gi] - 2'd1 :
                         cnt_q[gi];
      assign err_vec[gi] = (inc && !dec && cnt_q[gi] == 2'd3) ||
                           (dec && !inc && cnt_q[gi] == 2'd0);
    end
  endgenerate

  assign sberr_d = sberr_q | (|err_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q   <= '0;
      sberr_q <= 1'b0;
    end else begin
      if (bus.WRegEn_WB) mem_q[bus.WReg1_WB] <= bus.Dout_WB;
      cnt_q   <= cnt_d;
      sberr_q <= sberr_d;
    end
  end

  assign bus.Rdata1_ID = rdata1;
  assign bus.Rdata2_ID = rdata2;
  assign bus.Stall_ID  = haz_a || haz_b;
  assign bus.SbErr     = sberr_q;
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side register file with a pending-write scoreboard for the 5-stage pipeline. It is the consumer of the M/WB stage register outputs: it commits `Dout_WB` into register `WReg1_WB` when `WRegEn_WB` is set. It serves two operand reads to the ID stage. It tracks in-flight destination writes so ID stalls on read-after-write hazards instead of reading stale data.

## Interface
- `DATA_W`, 64, register width.
- `ADDR_W`, 3, register index width; depth = 2**ADDR_W (8 entries).
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `WRegEn_WB`  in  1  writeback write enable.
- `WReg1_WB`  in  ADDR_W  writeback destination index.
- `Dout_WB`  in  DATA_W  writeback data.
- `RReg1_ID`, `RReg2_ID`  in  ADDR_W  ID source indices A/B.
- `REn1_ID`, `REn2_ID`  in  1  source A/B actually used by the instruction in ID.
- `Rdata1_ID`, `Rdata2_ID`  out  DATA_W  source A/B read data (combinational).
- `IssueEn_ID`  in  1  instruction in ID writes a register and is requesting issue.
- `IssueReg_ID`  in  ADDR_W  its destination index.
- `Stall_ID`  out  1  hazard; ID must hold (combinational).
- `SbErr`  out  1  sticky scoreboard-overflow/underflow flag.

## Operation
- Storage: 2**ADDR_W × DATA_W registers. Every entry is writable, including entry 0. No hardwired zero.
- Write: on posedge, if `WRegEn_WB`, then `reg[WReg1_WB] <= Dout_WB`.
- Read: `Rdata1_ID = reg[RReg1_ID]` and `Rdata2_ID = reg[RReg2_ID]`. Reads are asynchronous and independent of the REn signals. Bypass is covered under Configuration.
- Scoreboard: one 2-bit pending count `cnt[i]` per register, so up to 3 writes to one register can be in flight (EX, M, WB).
- Issue gating: effective issue is `iss = IssueEn_ID && !Stall_ID`. Issue requests while stalled are ignored.
- Counter update on posedge, with `inc = iss && (i == IssueReg_ID)` and `dec = WRegEn_WB && (i == WReg1_WB)`:
  - inc only: `cnt+1`.
  - dec only: `cnt-1`.
  - both: unchanged.
- Overflow: inc-only with `cnt == 3`. The counter holds and `SbErr <= 1`.
- Underflow: dec-only with `cnt == 0`. The counter holds and `SbErr <= 1`. The register write still commits.
- `SbErr` clears only on `rst`.
- Hazard: `hazA = REn1_ID && cnt[RReg1_ID] != 0`, and likewise `hazB` for source B. `Stall_ID = hazA || hazB`, subject to the bypass exception below.
- The self-dependency case (source equals `IssueReg_ID` in the same instruction) is not a hazard. Only the pre-existing count is checked.

## Timing
- Reset (async, immediate):
  - All registers = 0.
  - All `cnt` = 0.
  - `SbErr` = 0.
  - Therefore `Stall_ID` = 0 and both `Rdata` outputs = 0.
- Write-to-read latency: 1 cycle without bypass. Data written at edge N is visible on `Rdata` after edge N.
- `Stall_ID` responds combinationally to RReg/REn/cnt. `cnt` changes take effect the cycle after the issue/WB edge.
- Reset asserted mid-operation discards all in-flight scoreboard state. Pipeline stages are reset by their own `rst`.

## Configuration
- `WB_BYPASS_EN` defined: same-cycle write-to-read bypass.
  - If `WRegEn_WB && WReg1_WB == RRegX_ID`, then `RdataX_ID = Dout_WB`.
  - A hazard on that source is suppressed when `cnt[RRegX_ID] == 1`, because the last in-flight write is completing this cycle.
  - Read latency becomes 0 cycles after WB.
- `WB_BYPASS_EN` undefined: no bypass. `Rdata` always reflects stored contents, and any `cnt != 0` stalls. This costs one extra stall cycle per RAW hazard.

## Test plan
- Reset, write/read:
  - Stimulus: assert `rst` mid-cycle → all `Rdata` = 0 immediately.
  - Stimulus: WB writes r3 = 0xDEADBEEF_CAFEF00D, then read r3 → value present the next cycle.
  - Both read ports return it simultaneously.
- RAW stall:
  - Stimulus: issue r5, then ID reads r5 with `REn1_ID` = 1 → `Stall_ID` = 1 until the WB write of r5 commits.
  - Without bypass: stall deasserts the cycle after the WB cycle.
  - With `WB_BYPASS_EN`: stall deasserts in the WB cycle and `Rdata1_ID` = `Dout_WB`.
- Unused source:
  - Stimulus: r5 pending, `RReg2_ID` = 5, `REn2_ID` = 0 → `Stall_ID` = 0.
- Multiple in flight:
  - Stimulus: issue r2 three times on consecutive cycles → `cnt` = 3; a fourth issue sets `SbErr` = 1 and `cnt` stays 3.
  - Stimulus: three WB writes to r2 → stall clears only after the third.
- Simultaneous issue and WB to the same register:
  - Stimulus: `cnt[r4]` = 1, `iss` to r4 and WB r4 on the same edge → `cnt[r4]` stays 1, r4 data updated, `SbErr` = 0.
- Underflow:
  - Stimulus: WB write to r6 with `cnt` = 0 → data committed, `SbErr` = 1.
  - `SbErr` holds until `rst`.
